// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// One bit per CLK; TX_OUT and Busy come straight from flops.
module uart_tx_frame #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nx;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_par_en;
   logic                  r_par;
   logic                  r_tx;
   logic                  r_busy;
   logic                  w_tx_nx;
   logic                  w_accept;

   assign w_accept = (r_state == IDLE) && DATA_VALID;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_data   <= '0;
         r_par_en <= 1'b0;
         r_par    <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_tx    <= w_tx_nx;
         r_busy  <= (w_state_nx != IDLE);
         if (w_accept) begin
            r_data   <= P_DATA;
            r_par_en <= PAR_EN;
            r_par    <= PAR_TYP ? ~^P_DATA : ^P_DATA;
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_tx_nx    = 1'b1;
      case (r_state)
         IDLE:    if (DATA_VALID) w_state_nx = START;
         START: begin
            w_state_nx = DATA;
            w_cnt_nx   = '0;
         end
         DATA: begin
            if (r_cnt == LAST_BIT) begin
               w_state_nx = r_par_en ? PARITY : STOP;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         PARITY:  w_state_nx = STOP;
         STOP:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
      // Line level is decoded from the next state so the flop shows the bit of the state being entered
      case (w_state_nx)
         START:   w_tx_nx = 1'b0;
         DATA:    w_tx_nx = r_data[w_cnt_nx];
         PARITY:  w_tx_nx = r_par;
         default: w_tx_nx = 1'b1;
      endcase
   end

   assign TX_OUT = r_tx;
   assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: expected line bits are queued when a
// request is driven and popped as the DUT shifts each bit out.
module tb_uart_tx_frame;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       Busy;

   int n_checks;
   int n_fail;
   logic q_exp[$];

   uart_tx_frame #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   // Reference frame: start, data LSB first, optional parity, stop
   task automatic push_frame(input logic [7:0] d, input logic pen, input logic ptyp, output int len);
      logic p;
      p = ptyp;
      q_exp.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         q_exp.push_back(d[i]);
         p = p ^ d[i];
      end
      if (pen) q_exp.push_back(p);
      q_exp.push_back(1'b1);
      len = pen ? 11 : 10;
   endtask

   task automatic test_reset();
      RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         n_checks++;
         if ({TX_OUT, Busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: tx=%b busy=%b, want tx=1 busy=0", c, TX_OUT, Busy);
         end
      end
      RST = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cycle();
         n_checks++;
         if ({TX_OUT, Busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d: tx=%b busy=%b, want tx=1 busy=0", c, TX_OUT, Busy);
         end
      end
   endtask

   task automatic test_no_parity();
      int len;
      logic e;
      P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      push_frame(P_DATA, PAR_EN, PAR_TYP, len);
      DATA_VALID = 1'b1;
      cycle();
      DATA_VALID = 1'b0;
      for (int i = 0; i < len; i++) begin
         e = q_exp.pop_front();
         n_checks++;
         if (TX_OUT !== e || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL no_parity bit %0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, e);
         end
         cycle();
      end
      n_checks++;
      if ({TX_OUT, Busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL no_parity_end: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
      end
   endtask

   task automatic test_parity();
      int len;
      logic e;
      logic rx;
      for (int k = 0; k < 2; k++) begin
         P_DATA = 8'h03; PAR_EN = 1'b1; PAR_TYP = k[0];
         push_frame(P_DATA, PAR_EN, PAR_TYP, len);
         DATA_VALID = 1'b1;
         cycle();
         DATA_VALID = 1'b0;
         rx = 1'b0;
         for (int i = 0; i < len; i++) begin
            e = q_exp.pop_front();
            if (i >= 1 && i <= 9) rx = rx ^ TX_OUT;
            n_checks++;
            if (TX_OUT !== e || Busy !== 1'b1) begin
               n_fail++;
               $display("FAIL parity typ=%0d bit %0d: tx=%b busy=%b, want tx=%b busy=1", k, i, TX_OUT, Busy, e);
            end
            cycle();
         end
         // Receiver-side view: data plus parity must XOR to the selected polarity
         n_checks++;
         if (rx !== k[0]) begin
            n_fail++;
            $display("FAIL rx_par_err typ=%0d: xor=%b, want %b", k, rx, k[0]);
         end
         n_checks++;
         if ({TX_OUT, Busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL parity_end typ=%0d: tx=%b busy=%b, want tx=1 busy=0", k, TX_OUT, Busy);
         end
      end
   endtask

   task automatic test_ignored();
      int len;
      logic e;
      P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      push_frame(P_DATA, PAR_EN, PAR_TYP, len);
      DATA_VALID = 1'b1;
      cycle();
      DATA_VALID = 1'b0;
      for (int i = 0; i < len; i++) begin
         e = q_exp.pop_front();
         n_checks++;
         if (TX_OUT !== e || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored bit %0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, e);
         end
         DATA_VALID = (i == 4);
         if (i == 4) begin
            P_DATA = 8'hFF; PAR_EN = 1'b1;
         end
         cycle();
      end
      DATA_VALID = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if ({TX_OUT, Busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL ignored_no_second cyc %0d: tx=%b busy=%b, want tx=1 busy=0", c, TX_OUT, Busy);
         end
         cycle();
      end
   endtask

   task automatic test_back_to_back();
      int len1;
      int len2;
      logic e;
      PAR_EN = 1'b1; PAR_TYP = 1'b0;
      push_frame(8'h55, 1'b1, 1'b0, len1);
      push_frame(8'hAA, 1'b1, 1'b0, len2);
      P_DATA = 8'h55;
      DATA_VALID = 1'b1;
      cycle();
      P_DATA = 8'hAA;
      for (int i = 0; i < len1; i++) begin
         e = q_exp.pop_front();
         n_checks++;
         if (TX_OUT !== e || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first bit %0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, e);
         end
         cycle();
      end
      n_checks++;
      if ({TX_OUT, Busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_gap: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
      end
      cycle();
      DATA_VALID = 1'b0;
      for (int i = 0; i < len2; i++) begin
         e = q_exp.pop_front();
         n_checks++;
         if (TX_OUT !== e || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second bit %0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, e);
         end
         cycle();
      end
      n_checks++;
      if ({TX_OUT, Busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_end: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
      end
   endtask

   task automatic test_reset_mid();
      int len;
      logic e;
      P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b1;
      push_frame(P_DATA, PAR_EN, PAR_TYP, len);
      DATA_VALID = 1'b1;
      cycle();
      DATA_VALID = 1'b0;
      // Start bit plus data bits 0..3; reset lands while data bit 3 is on the line
      for (int i = 0; i < 5; i++) begin
         e = q_exp.pop_front();
         n_checks++;
         if (TX_OUT !== e || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset bit %0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, e);
         end
         if (i < 4) cycle();
      end
      #2 RST = 1'b0;
      #1;
      n_checks++;
      if ({TX_OUT, Busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_mid_immediate: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
      end
      q_exp.delete();
      cycle();
      RST = 1'b1;
      cycle();
      n_checks++;
      if ({TX_OUT, Busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_mid_no_stop: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
      end
      P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0;
      push_frame(P_DATA, PAR_EN, PAR_TYP, len);
      DATA_VALID = 1'b1;
      cycle();
      DATA_VALID = 1'b0;
      for (int i = 0; i < len; i++) begin
         e = q_exp.pop_front();
         n_checks++;
         if (TX_OUT !== e || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset bit %0d: tx=%b busy=%b, want tx=%b busy=1", i, TX_OUT, Busy, e);
         end
         cycle();
      end
      n_checks++;
      if ({TX_OUT, Busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL post_reset_end: tx=%b busy=%b, want tx=1 busy=0", TX_OUT, Busy);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_no_parity();
      test_parity();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached before end of test");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter for the TX side of the system. It is the counterpart of the RX path's parity-checking receiver.
- Accepts a parallel byte with a valid strobe and serialises it one bit per CLK cycle, LSB first. CLK is the TX bit clock; baud prescaling happens upstream.
- Frame: start bit, DATA_WIDTH data bits, optional parity bit, one stop bit.
- Parity polarity matches the RX checker: PAR_TYP=0 even, PAR_TYP=1 odd.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (supported range 5..9).

Ports:
- CLK  input  1  TX bit clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel data to send; sampled only on accept.
- DATA_VALID  input  1  request to send P_DATA; single-cycle or held.
- PAR_EN  input  1  1 = insert parity bit; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- TX_OUT  output  1  serial line, registered, idles high.
- Busy  output  1  high while a frame is on the line, registered.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, TX_OUT=1, Busy=0, bit counter=0, shift/config registers=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - DATA_VALID=1 at a rising edge is an accept: P_DATA, PAR_EN and PAR_TYP are latched, and the parity bit is computed from the latched data (^data if even, ~^data if odd).
  - Next state START.
- START: TX_OUT=0, Busy=1, lasts 1 cycle, then DATA with counter=0.
- DATA:
  - TX_OUT=data[counter], Busy=1, one cycle per bit.
  - Counter increments each cycle.
  - On counter==DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT=parity bit, Busy=1, 1 cycle, then STOP.
- STOP: TX_OUT=1, Busy=1, 1 cycle, then IDLE.
- Latency: accept edge -> start bit appears on TX_OUT the next cycle (TX_OUT and Busy are driven by registered state).
- Frame length:
  - 2+DATA_WIDTH+PAR_EN cycles of Busy=1.
  - That is 10 cycles with no parity and 11 with parity at DATA_WIDTH=8.
- DATA_VALID while Busy=1: ignored, no queuing. Changes on P_DATA/PAR_EN/PAR_TYP mid-frame do not affect the frame in flight.
- Back-to-back: after STOP, at least one IDLE cycle (TX_OUT=1, Busy=0) precedes the next start bit.
  - DATA_VALID held high continuously produces frames separated by exactly one idle cycle.
- Reset mid-frame: immediate return to IDLE values (TX_OUT=1, Busy=0). The partial frame is abandoned and no stop bit is appended.
- No glitches: TX_OUT is driven directly from a flop, never from combinational decode.

Test Plan:
- Reset then idle: RST low 3 cycles, DATA_VALID=0 for 10 cycles -> TX_OUT=1 and Busy=0 throughout.
- No parity: P_DATA=8'hA5, PAR_EN=0, 1-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles; Busy=1 for exactly those 10 cycles.
- Even parity: P_DATA=8'h03, PAR_EN=1, PAR_TYP=0 -> 0,1,1,0,0,0,0,0,0,0(parity),1. Odd parity with the same data -> parity bit 1; the frame decodes in the RX model with par_err=0.
- Ignored request / stable data: DATA_VALID pulse and P_DATA change to 8'hFF at cycle 4 of an 8'h00 frame -> frame bits unchanged, no second frame.
- Back-to-back: DATA_VALID held high with 8'h55 then 8'hAA, PAR_EN=1 -> two 11-cycle frames with exactly one idle-high cycle between them.
- Reset mid-frame: assert RST during data bit 3 -> TX_OUT=1 and Busy=0 immediately; the next accept sends a complete correct frame.
